// File: rtl/mem_pair_processor.sv
// mem_pair_processor: captures DEPTH_A streamed samples into memory A.
// It then folds each adjacent pair A[2k], A[2k+1] into B[k] using a
// selectable unsigned operation (add, absdiff, max, min).
// B is exposed through a registered read port. Init restarts the block
// without a reset.
module mem_pair_processor #(
  parameter int DATA_W   = 8,
  parameter int DEPTH_A  = 8,
  parameter int ADDR_A_W = $clog2(DEPTH_A),
  parameter int ADDR_B_W = ((DEPTH_A / 2) > 1) ? $clog2(DEPTH_A / 2) : 1
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                Init,
  input  logic [DATA_W-1:0]   DataInA,
  input  logic [1:0]          Mode,
  input  logic [ADDR_B_W-1:0] RdAddrB,
  output logic [DATA_W-1:0]   RdDataB,
  output logic                Busy,
  output logic                Done,
  output logic                Sat
);

  localparam logic [1:0] ST_READA = 2'd0;
  localparam logic [1:0] ST_PROC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ABS = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;
  localparam logic [1:0] OP_MIN = 2'b11;

  localparam int B_SLOTS = 1 << ADDR_B_W;
  localparam logic [ADDR_A_W-1:0] LAST_A = ADDR_A_W'(DEPTH_A - 1);
  localparam logic [ADDR_B_W-1:0] LAST_B = ADDR_B_W'(DEPTH_A / 2 - 1);

  logic [1:0]          state;
  logic [ADDR_A_W-1:0] cnt;
  logic [ADDR_B_W-1:0] pair_cnt;
  logic [1:0]          mode_q;

  logic [DATA_W-1:0] mem_a [DEPTH_A];
  logic [DATA_W-1:0] mem_b [B_SLOTS];

  logic [ADDR_A_W-1:0] idx_even;
  logic [ADDR_A_W-1:0] idx_odd;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   op_res;
  logic                op_sat;

  // The pair being reduced always sits at A[2*pair_cnt] and the slot right after it.
  assign idx_even = ADDR_A_W'({pair_cnt, 1'b0});
  assign idx_odd  = idx_even + ADDR_A_W'(1);

  // Busy is forced low while reset is held, even if Init is already low.
  assign Busy = Reset && ((state == ST_PROC) || ((state == ST_READA) && !Init));
  assign Done = (state == ST_HALT);

  // Apply the operation latched at the end of capture to the current pair.
  always_comb begin
    op_a   = mem_a[idx_even];
    op_b   = mem_a[idx_odd];
    sum    = {1'b0, op_a} + {1'b0, op_b};
    op_res = '0;
    op_sat = 1'b0;
    case (mode_q)
      OP_ADD: begin
        if (sum[DATA_W]) begin
          op_res = '1;
          op_sat = 1'b1;
        end else begin
          op_res = sum[DATA_W-1:0];
        end
      end
      OP_ABS:  op_res = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
      OP_MAX:  op_res = (op_a >= op_b) ? op_a : op_b;
      OP_MIN:  op_res = (op_a <= op_b) ? op_a : op_b;
      default: op_res = '0;
    endcase
  end

  // Sequencer: capture into A, reduce pairs into B, then park in HALT until Init.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_READA;
      cnt      <= '0;
      pair_cnt <= '0;
      mode_q   <= OP_ADD;
      Sat      <= 1'b0;
    end else begin
      case (state)
        ST_READA: begin
          if (Init) begin
            cnt <= '0;
          end else if (cnt == LAST_A) begin
            cnt    <= '0;
            mode_q <= Mode;
            state  <= ST_PROC;
          end else begin
            cnt <= cnt + ADDR_A_W'(1);
          end
        end
        ST_PROC: begin
          if (op_sat) begin
            Sat <= 1'b1;
          end
          if (pair_cnt == LAST_B) begin
            pair_cnt <= '0;
            state    <= ST_HALT;
          end else begin
            pair_cnt <= pair_cnt + ADDR_B_W'(1);
          end
        end
        ST_HALT: begin
          if (Init) begin
            state <= ST_READA;
            Sat   <= 1'b0;
          end
        end
        default: state <= ST_READA;
      endcase
    end
  end

  // Memory A has no reset; a new run always overwrites it from index 0.
  always_ff @(posedge clock) begin
    if ((state == ST_READA) && !Init) begin
      mem_a[cnt] <= DataInA;
    end
  end

  // Memory B is cleared by reset and written one pair result per PROC edge.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < B_SLOTS; i++) begin
        mem_b[i] <= '0;
      end
    end else if (state == ST_PROC) begin
      mem_b[pair_cnt] <= op_res;
    end
  end

  // Registered read port; a same-edge write is not forwarded, so the old value is returned.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      RdDataB <= '0;
    end else begin
      RdDataB <= mem_b[RdAddrB];
    end
  end

endmodule

// File: tb/tb_mem_pair_processor.sv
// Testbench for mem_pair_processor (DATA_W=8, DEPTH_A=8).
// It applies a table of directed runs, a few hand-written corner sequences and
// randomized runs. Every result is compared against expectations built here.
module tb_mem_pair_processor;

  logic       clock;
  logic       Reset;
  logic       Init;
  logic [7:0] DataInA;
  logic [1:0] Mode;
  logic [1:0] RdAddrB;
  logic [7:0] RdDataB;
  logic       Busy;
  logic       Done;
  logic       Sat;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] samples;
    logic [31:0] expB;
    logic        expSat;
    logic        disturb;
  } vecT;

  vecT vecs [6];

  mem_pair_processor #(.DATA_W(8), .DEPTH_A(8)) dut (
    .clock   (clock),
    .Reset   (Reset),
    .Init    (Init),
    .DataInA (DataInA),
    .Mode    (Mode),
    .RdAddrB (RdAddrB),
    .RdDataB (RdDataB),
    .Busy    (Busy),
    .Done    (Done),
    .Sat     (Sat)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: reduce pairs from the sample list with plain integer arithmetic.
  task automatic modelRun(input logic [1:0] m, input logic [63:0] s,
                          output logic [31:0] expB, output logic expSat);
    int a;
    int b;
    int r;
    expB   = '0;
    expSat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = int'(s[63 - 16*k -: 8]);
      b = int'(s[55 - 16*k -: 8]);
      case (m)
        2'd0: begin
          r = a + b;
          if (r > 255) begin
            r = 255;
            expSat = 1'b1;
          end
        end
        2'd1: r = (a > b) ? a - b : b - a;
        2'd2: r = (a > b) ? a : b;
        default: r = (a < b) ? a : b;
      endcase
      expB[31 - 8*k -: 8] = 8'(r);
    end
  endtask

  // Stream one run of 8 samples, starting from READA with Init high.
  // Returns the edge count (from the first capture edge) at which Done was first seen.
  task automatic applyStimulus(input logic [1:0] m, input logic [63:0] s,
                               input logic disturb, output int doneEdge);
    Mode    = m;
    Init    = 1'b0;
    DataInA = s[63:56];
    doneEdge = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock);
      if (Done) begin
        doneEdge = e;
        break;
      end
      if (e < 8) DataInA = s[63 - 8*e -: 8];
      if (e == 4) checkOutput("busy_capture", int'(Busy), 1);
      if (e == 10) checkOutput("busy_proc", int'(Busy), 1);
      if (disturb && e == 8) begin
        Mode = ~m;
        Init = 1'b1;
      end
      if (disturb && e == 9) Init = 1'b0;
    end
  endtask

  // Read B back through the read port, check flags, then return to READA via Init.
  task automatic checkResults(input string tag, input logic [31:0] expB, input logic expSat);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      RdAddrB = 2'(k);
      @(negedge clock);
      checkOutput($sformatf("%s_b%0d", tag, k), int'(RdDataB), int'(expB[31 - 8*k -: 8]));
    end
    checkOutput({tag, "_sat"}, int'(Sat), int'(expSat));
    checkOutput({tag, "_done_hold"}, int'(Done), 1);
    Init = 1'b1;
    RdAddrB = 2'd0;
    @(negedge clock);
    checkOutput({tag, "_done_clr"}, int'(Done), 0);
    checkOutput({tag, "_sat_clr"}, int'(Sat), 0);
    checkOutput({tag, "_busy_idle"}, int'(Busy), 0);
    @(negedge clock);
    checkOutput({tag, "_b0_retained"}, int'(RdDataB), int'(expB[31:24]));
  endtask

  initial begin
    int doneEdge;
    logic [31:0] mB;
    logic        mSat;
    logic [1:0]  rm;
    logic [63:0] rs;

    nCompared   = 0;
    nMismatched = 0;

    vecs[0] = '{mode: 2'd1, samples: {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4},
                expB: {8'd1, 8'd1, 8'd1, 8'd1}, expSat: 1'b0, disturb: 1'b0};
    vecs[1] = '{mode: 2'd0, samples: {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4},
                expB: {8'd1, 8'd5, 8'd13, 8'd9}, expSat: 1'b0, disturb: 1'b0};
    vecs[2] = '{mode: 2'd2, samples: {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4},
                expB: {8'd1, 8'd3, 8'd7, 8'd5}, expSat: 1'b0, disturb: 1'b0};
    vecs[3] = '{mode: 2'd3, samples: {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4},
                expB: {8'd0, 8'd2, 8'd6, 8'd4}, expSat: 1'b0, disturb: 1'b0};
    vecs[4] = '{mode: 2'd0, samples: {8'd200, 8'd100, 8'd255, 8'd1, 8'd0, 8'd0, 8'd128, 8'd127},
                expB: {8'd255, 8'd255, 8'd0, 8'd255}, expSat: 1'b1, disturb: 1'b0};
    vecs[5] = '{mode: 2'd2, samples: {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd6, 8'd5, 8'd4},
                expB: {8'd1, 8'd3, 8'd7, 8'd5}, expSat: 1'b0, disturb: 1'b1};

    // Reset with Init low: everything must sit at reset values.
    Reset   = 1'b0;
    Init    = 1'b0;
    DataInA = 8'd0;
    Mode    = 2'd0;
    RdAddrB = 2'd0;
    for (int i = 0; i < 5; i++) @(negedge clock);
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_done", int'(Done), 0);
    checkOutput("rst_sat", int'(Sat), 0);
    checkOutput("rst_rddata", int'(RdDataB), 0);
    Init  = 1'b1;
    Reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_busy", int'(Busy), 0);

    // Directed table, including saturation and mode/Init disturbance during PROC.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].samples, vecs[v].disturb, doneEdge);
      checkOutput($sformatf("vec%0d_done_edge", v), doneEdge, 12);
      checkResults($sformatf("vec%0d", v), vecs[v].expB, vecs[v].expSat);
    end

    // Init raised after 3 captures discards them; the next run starts at A[0].
    Init = 1'b0;
    DataInA = 8'd50;
    @(negedge clock);
    DataInA = 8'd60;
    @(negedge clock);
    DataInA = 8'd70;
    @(negedge clock);
    Init = 1'b1;
    @(negedge clock);
    checkOutput("abort_busy", int'(Busy), 0);
    applyStimulus(2'd0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, doneEdge);
    checkOutput("abort_done_edge", doneEdge, 12);
    checkResults("abort", {8'd3, 8'd7, 8'd11, 8'd15}, 1'b0);

    // Reset asserted two edges into PROC clears B and the status flags.
    Mode = 2'd2;
    Init = 1'b0;
    DataInA = 8'd9;
    for (int e = 1; e <= 10; e++) @(negedge clock);
    Reset = 1'b0;
    #1;
    checkOutput("procrst_busy", int'(Busy), 0);
    checkOutput("procrst_done", int'(Done), 0);
    @(negedge clock);
    Init  = 1'b1;
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      RdAddrB = 2'(k);
      @(negedge clock);
      checkOutput($sformatf("procrst_b%0d", k), int'(RdDataB), 0);
    end

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      rm = 2'($urandom_range(0, 3));
      rs = {$urandom, $urandom};
      modelRun(rm, rs, mB, mSat);
      applyStimulus(rm, rs, 1'($urandom_range(0, 1)), doneEdge);
      checkOutput($sformatf("rnd%0d_done_edge", r), doneEdge, 12);
      checkResults($sformatf("rnd%0d", r), mB, mSat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
